// File: rtl/sram_pkg.sv
// Shared types and constants for the parameterised SRAM controller.
package sram_pkg;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-response delay line: RD_LAT register stages carrying a valid bit and data.
// Each data stage only loads when its input is valid, so the output holds between responses.
module sram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] valid_reg;
  logic [DATA_W-1:0] data_reg [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      if (in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[RD_LAT-1];
  assign out_data  = data_reg[RD_LAT-1];

endmodule

// File: rtl/sram_param_ctrl.sv
// Single-port SRAM controller with init sweep, byte-enable writes,
// fixed-latency reads and a sticky out-of-range error flag.
module sram_param_ctrl
  import sram_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 128,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                init_req,
  output logic                init_done,
  output logic                err,
  input  logic                err_clr
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || (DATA_W % 8) != 0) begin : g_param_check
    $error("sram_param_ctrl: RD_LAT must be 1..2 and DATA_W a multiple of 8");
  end

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                err_reg;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                fire, oor, rd_fire;
  logic [DATA_W-1:0]   rd_word;

  assign req_ready = (state_reg == S_READY);
  assign init_done = (state_reg == S_READY);
  assign err       = err_reg;
  assign fire      = req_valid && req_ready;
  assign oor       = ({1'b0, req_addr} >= DEPTH_L);
  assign rd_fire   = fire && !req_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_INIT: begin
        if (cnt_reg == LAST_ADDR) begin
          state_next = S_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      S_READY: begin
        cnt_next = '0;
        if (init_req) begin
          state_next = S_INIT;
        end
      end
      default: begin
        state_next = S_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // The array itself is never reset; the sweep alone defines its contents.
  always_ff @(posedge clk) begin
    if (state_reg == S_INIT) begin
      mem[cnt_reg] <= INIT_VAL;
    end else if (fire && req_we && !oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (!oor) begin
      rd_word = mem[req_addr];
    end
  end

  // Set has priority over clear so a fresh bad access is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (fire && oor) begin
      err_reg <= 1'b1;
    end else if (err_clr) begin
      err_reg <= 1'b0;
    end
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_word),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_sram_param_ctrl.sv
// Bench for sram_param_ctrl: two instances (DEPTH 128/RD_LAT 1 and DEPTH 100/RD_LAT 2)
// share stimulus and are checked every cycle against a behavioural model.
module tb_sram_param_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        init_req = 1'b0;
  logic        err_clr = 1'b0;

  logic [1:0]  rdy, done, rv, er;
  logic [15:0] rd [2];

  always #5 clk = ~clk;

  sram_param_ctrl #(.DATA_W(16), .DEPTH(128), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .init_req(init_req), .init_done(done[0]),
    .err(er[0]), .err_clr(err_clr)
  );

  sram_param_ctrl #(.DATA_W(16), .DEPTH(100), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .init_req(init_req), .init_done(done[1]),
    .err(er[1]), .err_clr(err_clr)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          depth_of [2] = '{128, 100};
  int          lat_of   [2] = '{1, 2};
  logic [15:0] mmem [2][128];
  bit          m_ready [2];
  int          m_left [2];
  bit          m_err [2];
  bit          sv [2][4];
  logic [15:0] sd [2][4];
  bit          exp_v [2];
  logic [15:0] exp_d [2] = '{16'h0, 16'h0};
  logic [15:0] last_rsp [2] = '{16'h0, 16'h0};
  int          rsp_cnt [2] = '{0, 0};
  int          base [2];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Model: memory contents, a ready flag with an init countdown, and a schedule
  // of responses keyed by the cycle they are due.
  task automatic model_step(input int d);
    int  s;
    bit  acc, bad;
    if (!rst_n) begin
      m_ready[d] = 1'b0;
      m_left[d]  = depth_of[d];
      m_err[d]   = 1'b0;
      for (int i = 0; i < 4; i++) sv[d][i] = 1'b0;
      for (int i = 0; i < 128; i++) mmem[d][i] = 16'h0;
      exp_v[d] = 1'b0;
      exp_d[d] = 16'h0;
      return;
    end
    acc = m_ready[d] && req_valid;
    bad = acc && (int'(req_addr) >= depth_of[d]);
    if (acc && req_we && !bad) begin
      if (req_be[0]) mmem[d][req_addr][7:0]  = req_wdata[7:0];
      if (req_be[1]) mmem[d][req_addr][15:8] = req_wdata[15:8];
    end
    if (acc && !req_we) begin
      s = (cyc + lat_of[d] - 1) % 4;
      sv[d][s] = 1'b1;
      sd[d][s] = bad ? 16'h0 : mmem[d][req_addr];
    end
    if (bad) m_err[d] = 1'b1;
    else if (err_clr) m_err[d] = 1'b0;
    if (m_ready[d]) begin
      if (init_req) begin
        m_ready[d] = 1'b0;
        m_left[d]  = depth_of[d];
        for (int i = 0; i < 128; i++) mmem[d][i] = 16'h0;
      end
    end else begin
      m_left[d]--;
      if (m_left[d] == 0) m_ready[d] = 1'b1;
    end
    s = cyc % 4;
    exp_v[d] = sv[d][s];
    if (sv[d][s]) exp_d[d] = sd[d][s];
    sv[d][s] = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0);
    model_step(1);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("req_ready", d, rdy[d], m_ready[d]);
      check("init_done", d, done[d], m_ready[d]);
      check("err", d, er[d], m_err[d]);
      check("rsp_valid", d, rv[d], exp_v[d]);
      check("rsp_rdata", d, rd[d], exp_d[d]);
      if (rv[d]) begin
        last_rsp[d] = rd[d];
        rsp_cnt[d]++;
      end
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    init_req  = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic op(input bit we, input int addr, input logic [15:0] wd, input logic [1:0] be,
                    input bit ini, input bit clr);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = 7'(addr);
    req_wdata = wd;
    req_be    = be;
    init_req  = ini;
    err_clr   = clr;
  endtask

  // Counts rising edges from now until each instance reports init_done.
  task automatic measure_init(input int exp_a, input int exp_b);
    int n = 0;
    int ta = -1;
    int tb = -1;
    while ((ta < 0 || tb < 0) && n < 400) begin
      @(posedge clk);
      #2;
      n++;
      if (ta < 0 && done[0]) ta = n;
      if (tb < 0 && done[1]) tb = n;
    end
    check("init_cycles", 0, ta, exp_a);
    check("init_cycles", 1, tb, exp_b);
  endtask

  task automatic check_last(input string name, input logic [15:0] ea, input logic [15:0] eb);
    check(name, 0, last_rsp[0], ea);
    check(name, 1, last_rsp[1], eb);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", d, rdy[d], 0);
      check("rst_rsp_valid", d, rv[d], 0);
      check("rst_rsp_rdata", d, rd[d], 0);
      check("rst_err", d, er[d], 0);
    end
    rst_n = 1'b1;
    measure_init(128, 100);

    op(0, 3, 16'h0, 2'b00, 0, 0);
    op(0, 99, 16'h0, 2'b00, 0, 0);
    repeat (3) idle_cycle();
    check_last("init_read", 16'h0000, 16'h0000);

    op(1, 5, 16'hABCD, 2'b01, 0, 0);
    op(0, 5, 16'h0, 2'b00, 0, 0);
    repeat (3) idle_cycle();
    check_last("be_read", 16'h00CD, 16'h00CD);

    op(1, 7, 16'h1234, 2'b11, 0, 0);
    op(0, 7, 16'h0, 2'b00, 0, 0);
    repeat (3) idle_cycle();
    check_last("raw_read", 16'h1234, 16'h1234);

    base = rsp_cnt;
    op(0, 5, 16'h0, 2'b00, 0, 0);
    op(0, 7, 16'h0, 2'b00, 0, 0);
    op(0, 5, 16'h0, 2'b00, 0, 0);
    op(0, 7, 16'h0, 2'b00, 0, 0);
    repeat (3) idle_cycle();
    check("b2b_count", 0, rsp_cnt[0] - base[0], 4);
    check("b2b_count", 1, rsp_cnt[1] - base[1], 4);
    check_last("b2b_last", 16'h1234, 16'h1234);

    op(1, 100, 16'hFFFF, 2'b11, 0, 0);
    idle_cycle();
    check("err_set", 1, er[1], 1);
    check("err_inrange", 0, er[0], 0);
    op(0, 100, 16'h0, 2'b00, 0, 0);
    repeat (3) idle_cycle();
    check_last("oor_read", 16'hFFFF, 16'h0000);
    err_clr = 1'b1;
    idle_cycle();
    check("err_clr", 1, er[1], 0);
    op(1, 100, 16'h0, 2'b11, 0, 1);
    idle_cycle();
    check("err_set_wins", 1, er[1], 1);
    err_clr = 1'b1;
    idle_cycle();

    op(1, 9, 16'h5A5A, 2'b11, 0, 0);
    op(0, 9, 16'h0, 2'b00, 1, 0);
    idle_cycle();
    check("init_done_fall", 0, done[0], 0);
    check("init_done_fall", 1, done[1], 0);
    measure_init(128, 100);
    check_last("pre_init_read", 16'h5A5A, 16'h5A5A);
    op(0, 9, 16'h0, 2'b00, 0, 0);
    repeat (3) idle_cycle();
    check_last("post_init_read", 16'h0000, 16'h0000);

    base = rsp_cnt;
    op(0, 9, 16'h0, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    check("flush_count", 0, rsp_cnt[0] - base[0], 1);
    check("flush_count", 1, rsp_cnt[1] - base[1], 0);
    repeat (50) idle_cycle();
    base = rsp_cnt;
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
    measure_init(128, 100);
    check("midsweep_rsp", 0, rsp_cnt[0] - base[0], 0);
    check("midsweep_rsp", 1, rsp_cnt[1] - base[1], 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(90, 127)) : 7'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      req_be    = 2'($urandom);
      init_req  = ($urandom_range(0, 199) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_param_ctrl.md
SRAM_PARAM_CTRL -- requirements
Module: sram_param_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 128, number of words (any value >= 2, not required to be a power of two).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2 only.
REQ-005 SHALL have parameter INIT_VAL, default 0, DATA_W-bit value written to every word during the init sweep.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1 bit, request present.
REQ-009 SHALL have port req_ready, output, 1 bit, request can be accepted.
REQ-010 SHALL have port req_we, input, 1 bit, 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_W bits, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W bits, write data.
REQ-013 SHALL have port req_be, input, DATA_W/8 bits, byte enables; bit i enables byte i.
REQ-014 SHALL have port rsp_valid, output, 1 bit, read data valid (single-cycle pulse).
REQ-015 SHALL have port rsp_rdata, output, DATA_W bits, read data.
REQ-016 SHALL have port init_req, input, 1 bit, requests a re-initialisation sweep.
REQ-017 SHALL have port init_done, output, 1 bit, high while in state S_READY.
REQ-018 SHALL have port err, output, 1 bit, sticky out-of-range address flag.
REQ-019 SHALL have port err_clr, input, 1 bit, clears err.

Function
REQ-020 SHALL implement FSM states S_INIT and S_READY.
REQ-021 In S_INIT: SHALL write INIT_VAL to addresses 0..DEPTH-1 at one word per cycle; SHALL hold req_ready=0; SHALL move to S_READY after address DEPTH-1 is written, i.e. exactly DEPTH cycles after entry.
REQ-022 In S_READY: SHALL hold req_ready=1; a request is accepted on any cycle where req_valid && req_ready.
REQ-023 Accepted write: SHALL update only the bytes with req_be set, at the accepting edge; the other bytes retain their value.
REQ-024 Accepted read: SHALL pulse rsp_valid exactly RD_LAT cycles after acceptance, with the addressed word on rsp_rdata; back-to-back reads SHALL give back-to-back responses in order.
REQ-025 The response path has no backpressure; every accepted read SHALL produce exactly one response.
REQ-026 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-027 req_addr >= DEPTH: a write SHALL be dropped and a read SHALL return all-zero data with normal latency; in both cases err SHALL be set on the accepting edge.
REQ-028 err_clr SHALL clear err; if err_clr and a new out-of-range access occur in the same cycle, err SHALL remain 1 (set wins).
REQ-029 init_req sampled in S_READY SHALL move the FSM to S_INIT on the next cycle, restarting the sweep from address 0.
REQ-030 If a request and init_req occur in the same cycle, the request SHALL be accepted first.
REQ-031 Reads already in flight SHALL still complete with their pre-init data.
REQ-032 init_req SHALL be ignored while already in S_INIT.
REQ-033 rsp_rdata SHALL hold its last value while rsp_valid=0.

Reset
REQ-034 On rst_n=0: FSM SHALL enter S_INIT with the sweep counter at 0.
REQ-035 Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, err=0; the read pipeline SHALL be flushed.
REQ-036 Reset mid-sweep or mid-read SHALL discard all in-flight responses and restart the sweep at address 0 after rst_n deasserts.
REQ-037 The memory array SHALL NOT be reset directly; its contents SHALL be defined by the sweep alone.

Structure
REQ-038 Package sram_pkg SHALL hold the state enum {S_INIT, S_READY} and the constants RD_LAT_MIN=1 and RD_LAT_MAX=2.
REQ-039 The read-latency stage SHALL be a sub-module sram_rd_pipe, parameterised by DATA_W and RD_LAT, carrying a valid bit and data.
REQ-040 An elaboration-time check SHALL reject RD_LAT outside 1..2 and DATA_W not a multiple of 8.

Verification
REQ-041 Reset then idle (DEPTH=128): init_done rises exactly 128 cycles after rst_n deasserts; a read of any address returns 0x0000.
REQ-042 Write addr 5 data 0xABCD be=2'b01, then read addr 5 -> rsp_rdata=0x00CD after RD_LAT cycles, for both RD_LAT=1 and RD_LAT=2.
REQ-043 Write addr 7 data 0x1234, then read addr 7 on the next cycle -> 0x1234; 4 back-to-back reads -> 4 consecutive rsp_valid pulses in order.
REQ-044 DEPTH=100, write addr 100 -> err=1 and no array change; read addr 100 -> rsp_rdata=0; err_clr -> err=0; err_clr together with a new bad access -> err stays 1.
REQ-045 Read accepted in the same cycle as init_req -> response carries the old data; init_done falls, then rises again after DEPTH cycles; rst_n pulsed at sweep address 50 -> sweep restarts at 0 and no rsp_valid appears.
